// File: rtl/dtmr_fault_mgr.sv
`default_nettype none
// ============================================================================
// Module   : dtmr_fault_mgr
// Purpose  : Dynamic-TMR mode controller. Filters voter fault flags, resets
//            faulty copies, retires chronic failures and raises an alarm.
// Revision : 1.0 - initial release
// ============================================================================
module dtmr_fault_mgr #(
    parameter int FAULT_THRESH = 4,
    parameter int CLEAN_WIN    = 16,
    parameter int RECOV_CYC    = 8,
    parameter int MAX_RECOV    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trig,
    input  logic [2:0] fault,
    output logic       state,
    output logic [2:0] copy_rst,
    output logic [2:0] perm_fail,
    output logic       alarm,
    output logic [7:0] evt_cnt
);

    localparam int c_CNT_W = $clog2(FAULT_THRESH + 1);
    localparam int c_CLN_W = $clog2(CLEAN_WIN + 1);
    localparam int c_RC_W  = $clog2(RECOV_CYC + 1);
    localparam int c_RCN_W = (MAX_RECOV < 1) ? 1 : $clog2(MAX_RECOV + 1);

    typedef enum logic [1:0] {
        S_SIMPLEX = 2'd0,
        S_TMR     = 2'd1,
        S_RECOVER = 2'd2,
        S_ALARM   = 2'd3
    } fsm_t;

    fsm_t               r_fsm;
    fsm_t               w_nxt;
    logic [c_CNT_W-1:0] r_cnt  [3];
    logic [c_RCN_W-1:0] r_rcnt [3];
    logic [c_CLN_W-1:0] r_clean;
    logic [c_CLN_W-1:0] w_clean_nxt;
    logic [c_RC_W-1:0]  r_rc;
    logic [c_RC_W-1:0]  w_rc_nxt;
    logic [2:0]         r_target;
    logic [2:0]         w_target_nxt;
    logic               r_state;
    logic [2:0]         r_copy_rst;
    logic [2:0]         w_copy_rst_nxt;
    logic [2:0]         r_perm_fail;
    logic [2:0]         w_perm_nxt;
    logic               r_alarm;
    logic [7:0]         r_evt_cnt;

    logic               w_monitor;
    logic [2:0]         w_eff;
    logic [2:0]         w_decl;
    logic [2:0]         w_dsel;
    logic [2:0]         w_at_max;
    logic [2:0]         w_rcnt_inc;
    logic               w_multi;
    logic               w_clean_ok;
    logic               w_evt_inc;

    // Retired copies and the copy under reset are excluded from every check.
    assign w_monitor  = (r_fsm == S_TMR) || (r_fsm == S_RECOVER);
    assign w_eff      = w_monitor ? (fault & ~r_perm_fail &
                        ((r_fsm == S_RECOVER) ? ~r_target : 3'b111)) : 3'b000;
    assign w_multi    = (w_eff[0] & w_eff[1]) | (w_eff[0] & w_eff[2]) | (w_eff[1] & w_eff[2]);
    assign w_dsel     = w_decl & (~w_decl + 3'd1);
    assign w_clean_ok = (w_eff == 3'b000) && !trig;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_copy
            assign w_decl[gi]   = w_eff[gi] && (r_cnt[gi] == c_CNT_W'(FAULT_THRESH - 1));
            assign w_at_max[gi] = (r_rcnt[gi] >= c_RCN_W'(MAX_RECOV));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt[gi]  <= '0;
                    r_rcnt[gi] <= '0;
                end else begin
                    if (!w_eff[gi] || w_decl[gi])
                        r_cnt[gi] <= '0;
                    else
                        r_cnt[gi] <= r_cnt[gi] + c_CNT_W'(1);
                    if (w_rcnt_inc[gi])
                        r_rcnt[gi] <= r_rcnt[gi] + c_RCN_W'(1);
                end
            end
        end
    endgenerate

    always_comb begin
        w_nxt          = r_fsm;
        w_clean_nxt    = r_clean;
        w_rc_nxt       = r_rc;
        w_target_nxt   = r_target;
        w_copy_rst_nxt = r_copy_rst;
        w_perm_nxt     = r_perm_fail;
        w_rcnt_inc     = 3'b000;
        w_evt_inc      = 1'b0;
        case (r_fsm)
            S_SIMPLEX: begin
                w_clean_nxt = '0;
                if (trig)
                    w_nxt = S_TMR;
            end
            S_TMR: begin
                if (!w_clean_ok)
                    w_clean_nxt = '0;
                else if (r_clean != c_CLN_W'(CLEAN_WIN))
                    w_clean_nxt = r_clean + c_CLN_W'(1);
                if (w_multi) begin
                    w_nxt = S_ALARM;
                end else if (w_decl != 3'b000) begin
                    w_evt_inc = 1'b1;
                    if (r_perm_fail != 3'b000) begin
                        w_nxt = S_ALARM;
                    end else if ((w_dsel & w_at_max) == 3'b000) begin
                        w_nxt          = S_RECOVER;
                        w_target_nxt   = w_dsel;
                        w_rcnt_inc     = w_dsel;
                        w_rc_nxt       = '0;
                        w_clean_nxt    = '0;
                        w_copy_rst_nxt = r_copy_rst | w_dsel;
                    end else begin
                        // Recovery budget exhausted: retire the copy and keep it in reset.
                        w_perm_nxt     = r_perm_fail | w_dsel;
                        w_copy_rst_nxt = r_copy_rst | w_dsel;
                    end
                end else if (w_clean_ok && (r_clean == c_CLN_W'(CLEAN_WIN - 1)) &&
                             (r_perm_fail == 3'b000)) begin
                    w_nxt = S_SIMPLEX;
                end
            end
            S_RECOVER: begin
                w_clean_nxt = '0;
                if (w_decl != 3'b000) begin
                    w_evt_inc = 1'b1;
                    w_nxt     = S_ALARM;
                end else if (r_rc == c_RC_W'(RECOV_CYC - 1)) begin
                    w_nxt          = S_TMR;
                    w_copy_rst_nxt = r_copy_rst & ~r_target;
                end else begin
                    w_rc_nxt = r_rc + c_RC_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= S_SIMPLEX;
            r_clean     <= '0;
            r_rc        <= '0;
            r_target    <= 3'b000;
            r_state     <= 1'b0;
            r_copy_rst  <= 3'b000;
            r_perm_fail <= 3'b000;
            r_alarm     <= 1'b0;
            r_evt_cnt   <= 8'd0;
        end else begin
            r_fsm       <= w_nxt;
            r_clean     <= w_clean_nxt;
            r_rc        <= w_rc_nxt;
            r_target    <= w_target_nxt;
            r_state     <= (w_nxt != S_SIMPLEX);
            r_copy_rst  <= w_copy_rst_nxt;
            r_perm_fail <= w_perm_nxt;
            r_alarm     <= r_alarm | (w_nxt == S_ALARM);
            if (w_evt_inc && (r_evt_cnt != 8'hFF))
                r_evt_cnt <= r_evt_cnt + 8'd1;
        end
    end

    assign state     = r_state;
    assign copy_rst  = r_copy_rst;
    assign perm_fail = r_perm_fail;
    assign alarm     = r_alarm;
    assign evt_cnt   = r_evt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dtmr_fault_mgr.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtmr_fault_mgr
// Purpose  : Directed self-checking bench for dtmr_fault_mgr.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dtmr_fault_mgr;

    logic       clk;
    logic       rst_n;
    logic       trig;
    logic [2:0] fault;
    logic       state;
    logic [2:0] copy_rst;
    logic [2:0] perm_fail;
    logic       alarm;
    logic [7:0] evt_cnt;

    int n_cmp;
    int n_err;

    dtmr_fault_mgr #(
        .FAULT_THRESH (4),
        .CLEAN_WIN    (16),
        .RECOV_CYC    (8),
        .MAX_RECOV    (2)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig      (trig),
        .fault     (fault),
        .state     (state),
        .copy_rst  (copy_rst),
        .perm_fail (perm_fail),
        .alarm     (alarm),
        .evt_cnt   (evt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        trig  = 1'b0;
        fault = 3'b000;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // Raise trig for one sampled edge and return with the FSM in TMR.
    task automatic go_tmr();
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Simplex ignores faults entirely.
        do_reset();
        chk("rst_state", 8'(state), 8'h0);
        chk("rst_evt", evt_cnt, 8'h0);
        fault = 3'b111;
        tick(20);
        chk("t1_state", 8'(state), 8'h0);
        chk("t1_copy_rst", 8'(copy_rst), 8'h0);
        chk("t1_alarm", 8'(alarm), 8'h0);
        chk("t1_evt", evt_cnt, 8'h0);

        // Single declaration, recovery, clean window back to simplex.
        do_reset();
        go_tmr();
        chk("t2_state_tmr", 8'(state), 8'h1);
        fault = 3'b001;
        tick(3);
        chk("t2_pre_decl_evt", evt_cnt, 8'h0);
        chk("t2_pre_decl_rst", 8'(copy_rst), 8'h0);
        tick(1);
        fault = 3'b000;
        chk("t2_evt", evt_cnt, 8'h1);
        chk("t2_copy_rst_on", 8'(copy_rst), 8'h1);
        tick(7);
        chk("t2_copy_rst_last", 8'(copy_rst), 8'h1);
        tick(1);
        chk("t2_copy_rst_off", 8'(copy_rst), 8'h0);
        chk("t2_state_after_rec", 8'(state), 8'h1);
        tick(15);
        chk("t2_clean_15", 8'(state), 8'h1);
        tick(1);
        chk("t2_clean_16", 8'(state), 8'h0);

        // Interrupted persistence never declares.
        do_reset();
        go_tmr();
        fault = 3'b010;
        tick(3);
        fault = 3'b000;
        tick(1);
        fault = 3'b010;
        tick(3);
        fault = 3'b000;
        tick(1);
        chk("t3_copy_rst", 8'(copy_rst), 8'h0);
        chk("t3_evt", evt_cnt, 8'h0);
        chk("t3_state", 8'(state), 8'h1);

        // Two recoveries of copy 3, then permanent retirement.
        do_reset();
        go_tmr();
        for (int ep = 0; ep < 2; ep++) begin
            fault = 3'b100;
            tick(4);
            fault = 3'b000;
            chk($sformatf("t4_rec%0d_rst", ep), 8'(copy_rst), 8'h4);
            chk($sformatf("t4_rec%0d_evt", ep), evt_cnt, 8'(ep + 1));
            tick(8);
            chk($sformatf("t4_rec%0d_rel", ep), 8'(copy_rst), 8'h0);
        end
        fault = 3'b100;
        tick(4);
        fault = 3'b000;
        chk("t4_perm", 8'(perm_fail), 8'h4);
        chk("t4_perm_rst", 8'(copy_rst), 8'h4);
        chk("t4_evt3", evt_cnt, 8'h3);
        tick(40);
        chk("t4_stay_tmr", 8'(state), 8'h1);
        chk("t4_rst_held", 8'(copy_rst), 8'h4);
        chk("t4_no_alarm", 8'(alarm), 8'h0);

        // Multi-copy fault goes straight to alarm; only reset exits.
        do_reset();
        go_tmr();
        fault = 3'b011;
        tick(1);
        chk("t5_alarm", 8'(alarm), 8'h1);
        chk("t5_state", 8'(state), 8'h1);
        fault = 3'b111;
        trig  = 1'b1;
        tick(10);
        fault = 3'b000;
        trig  = 1'b0;
        tick(20);
        chk("t5_alarm_sticky", 8'(alarm), 8'h1);
        chk("t5_evt_frozen", evt_cnt, 8'h0);
        chk("t5_rst_hold", 8'(copy_rst), 8'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_alarm", 8'(alarm), 8'h0);
        chk("t5_async_state", 8'(state), 8'h0);
        rst_n = 1'b1;

        // Non-target declaration during recovery.
        do_reset();
        go_tmr();
        fault = 3'b001;
        tick(4);
        fault = 3'b010;
        tick(3);
        chk("t6_no_alarm_yet", 8'(alarm), 8'h0);
        tick(1);
        fault = 3'b000;
        chk("t6_alarm", 8'(alarm), 8'h1);
        tick(10);
        chk("t6_rst_held", 8'(copy_rst), 8'h1);

        // Reset asserted mid-recovery releases copy_rst without a clock edge.
        do_reset();
        go_tmr();
        fault = 3'b001;
        tick(4);
        fault = 3'b000;
        tick(3);
        chk("t6b_in_recover", 8'(copy_rst), 8'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6b_async_rst", 8'(copy_rst), 8'h0);
        chk("t6b_async_state", 8'(state), 8'h0);
        rst_n = 1'b1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
